// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared definitions for the scanning multiplexer family.
//   MODE_MANUAL / MODE_SCAN : values of the mode input.
//   ST_IDLE / ST_MANUAL / ST_SCAN : operating-state encoding.
//   sel_width()             : index width for n items (minimum 1 bit).
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  function automatic int unsigned sel_width(input int unsigned n);
    if (n <= 1) return 1;
    return unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: combinational next-channel finder for round-robin scanners.
//   cur      in  : current channel index
//   mask     in  : per-channel enable (1 = eligible)
//   nxt      out : next enabled channel above cur, wrapping to the lowest
//   nxt_wrap out : the step to nxt does not increase the index (end of sweep)
//   any      out : at least one channel is enabled
// The mask is rotated so bit k refers to channel cur+1+k, then the lowest set
// bit is priority-encoded; cur itself is the last candidate.
module mux_scan_next #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2
) (
  input  logic [SELW-1:0]     cur,
  input  logic [CHANNELS-1:0] mask,
  output logic [SELW-1:0]     nxt,
  output logic                nxt_wrap,
  output logic                any
);

  logic [CHANNELS-1:0] rot;
  int unsigned         off;
  int unsigned         nxt_idx;

  // Channel index at rotated position k relative to base.
  function automatic int unsigned chan_at(input int unsigned base, input int unsigned k);
    int unsigned i;
    i = base + 1 + k;
    if (i >= CHANNELS) i = i - CHANNELS;
    return i;
  endfunction

  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      rot[k] = mask[chan_at(32'(cur), k)];
    end
  end

  always_comb begin
    any = 1'b0;
    off = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (rot[k] && !any) begin
        any = 1'b1;
        off = k;
      end
    end
    nxt_idx  = chan_at(32'(cur), off);
    nxt      = SELW'(nxt_idx);
    nxt_wrap = any && (nxt <= cur);
  end

endmodule

// File: rtl/mux_scan_nch.sv
// mux_scan_nch: registered N-channel multiplexer with manual select or
// automatic round-robin scan and a programmable dwell per channel.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   en       : global enable, 0 freezes all state
//   mode     : 0 = manual (sel chooses), 1 = scan (auto advance every DWELL)
//   sel      : manual channel select; out-of-range values are ignored
//   din      : packed channel data, channel i at din[i*WIDTH +: WIDTH]
//   ch_mask  : per-channel enable, present only with MUX_SCAN_MASK_EN
//   F        : registered selected data
//   ch       : channel currently driven on F
//   ch_stb   : one-cycle pulse in the first cycle ch shows a new value
//   wrap     : one-cycle pulse when a scan step does not increase ch
// Optional feature macro: MUX_SCAN_MASK_EN (adds ch_mask).
module mux_scan_nch
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 50,
  localparam int unsigned SELW    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          F,
  output logic [SELW-1:0]           ch,
  output logic                      ch_stb,
  output logic                      wrap
);

  localparam int unsigned     CNTW     = sel_width(DWELL);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    f_q, f_d;
  logic [SELW-1:0]     ch_q, ch_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                stb_q, stb_d;
  logic                wrap_q, wrap_d;

  logic [CHANNELS-1:0] mask;
  logic [WIDTH-1:0]    chan [CHANNELS];
  logic [SELW-1:0]     nxt;
  logic                nxt_wrap;
  logic                any_en;
  logic                sel_ok;

`ifdef MUX_SCAN_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chan[i] = din[i*WIDTH +: WIDTH];
  end

  mux_scan_next #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_next (
    .cur      (ch_q),
    .mask     (mask),
    .nxt      (nxt),
    .nxt_wrap (nxt_wrap),
    .any      (any_en)
  );

  assign sel_ok = (32'(sel) < CHANNELS) && mask[sel];

  always_comb begin
    state_d = ST_IDLE;
    if (en) state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;

    f_d    = f_q;
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;

    case (state_d)
      ST_MANUAL: begin
        cnt_d = '0;
        if (sel_ok) begin
          ch_d = sel;
          f_d  = chan[sel];
        end
      end
      ST_SCAN: begin
        if (state_q == ST_MANUAL) begin
          // Entry edge from manual: restart dwell, never advance here.
          cnt_d = '0;
          if (any_en) f_d = chan[ch_q];
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (any_en) begin
            ch_d   = nxt;
            f_d    = chan[nxt];
            wrap_d = nxt_wrap;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
          if (any_en) f_d = chan[ch_q];
        end
      end
      default: ;  // idle: hold everything
    endcase

    stb_d = (ch_d != ch_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      wrap_q  <= wrap_d;
    end
  end

  assign F      = f_q;
  assign ch     = ch_q;
  assign ch_stb = stb_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_mux_scan_nch.sv
// tb_mux_scan_nch: directed bench for mux_scan_nch.
//   dut  : WIDTH=4, CHANNELS=4, DWELL=3, din = {4,3,2,1}
//   dut3 : WIDTH=4, CHANNELS=3, DWELL=3, din = {7,6,5} (out-of-range select)
module tb_mux_scan_nch;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] din;
  logic [3:0]  F;
  logic [1:0]  ch;
  logic        ch_stb;
  logic        wrap;

  logic [1:0]  sel3;
  logic [11:0] din3;
  logic [3:0]  F3;
  logic [1:0]  ch3;
  logic        ch_stb3;
  logic        wrap3;

  int n_pass;
  int n_total;

`ifdef MUX_SCAN_MASK_EN
  logic [3:0] ch_mask;
  logic [2:0] ch_mask3;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_scan_nch #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .sel     (sel),
    .din     (din),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask (ch_mask),
`endif
    .F       (F),
    .ch      (ch),
    .ch_stb  (ch_stb),
    .wrap    (wrap)
  );

  mux_scan_nch #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .sel     (sel3),
    .din     (din3),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask (ch_mask3),
`endif
    .F       (F3),
    .ch      (ch3),
    .ch_stb  (ch_stb3),
    .wrap    (wrap3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #7;
    n_total++; if (F !== 4'd0) $display("FAIL rst_F: got %0d exp 0", F); else n_pass++;
    n_total++; if (ch !== 2'd0) $display("FAIL rst_ch: got %0d exp 0", ch); else n_pass++;
    n_total++; if (ch_stb !== 1'b0) $display("FAIL rst_stb: got %b exp 0", ch_stb); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL rst_wrap: got %b exp 0", wrap); else n_pass++;
    n_total++; if (F3 !== 4'd0) $display("FAIL rst_F3: got %0d exp 0", F3); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_manual();
    en = 1'b1; mode = 1'b0; sel = 2'd2;
    step();
    n_total++; if (F !== 4'd3) $display("FAIL man_F_sel2: got %0d exp 3", F); else n_pass++;
    n_total++; if (ch !== 2'd2) $display("FAIL man_ch_sel2: got %0d exp 2", ch); else n_pass++;
    n_total++; if (ch_stb !== 1'b1) $display("FAIL man_stb_sel2: got %b exp 1", ch_stb);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (ch_stb !== 1'b0) $display("FAIL man_stb_hold%0d: got %b exp 0", i, ch_stb);
      else n_pass++;
      n_total++; if (F !== 4'd3) $display("FAIL man_F_hold%0d: got %0d exp 3", i, F); else n_pass++;
    end
    sel = 2'd0;
    step();
    n_total++; if (F !== 4'd1) $display("FAIL man_F_sel0: got %0d exp 1", F); else n_pass++;
    n_total++; if (ch_stb !== 1'b1) $display("FAIL man_stb_sel0: got %b exp 1", ch_stb);
    else n_pass++;
    din = 16'h4329;  // live update of channel 0
    step();
    n_total++; if (F !== 4'd9) $display("FAIL man_F_live: got %0d exp 9", F); else n_pass++;
    n_total++; if (ch_stb !== 1'b0) $display("FAIL man_stb_live: got %b exp 0", ch_stb);
    else n_pass++;
    din = 16'h4321;
    step();
    n_total++; if (F !== 4'd1) $display("FAIL man_F_restore: got %0d exp 1", F); else n_pass++;
  endtask

  task automatic test_scan();
    logic [3:0] ef;
    logic [1:0] ec;
    logic       es;
    logic       ew;
    mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      ef = 4'((i / 3) % 4 + 1);
      ec = 2'((i / 3) % 4);
      es = (i > 0) && (i % 3 == 0);
      ew = (i == 12);
      n_total++; if (F !== ef) $display("FAIL scan_F[%0d]: got %0d exp %0d", i, F, ef);
      else n_pass++;
      n_total++; if (ch !== ec) $display("FAIL scan_ch[%0d]: got %0d exp %0d", i, ch, ec);
      else n_pass++;
      n_total++; if (ch_stb !== es) $display("FAIL scan_stb[%0d]: got %b exp %b", i, ch_stb, es);
      else n_pass++;
      n_total++; if (wrap !== ew) $display("FAIL scan_wrap[%0d]: got %b exp %b", i, wrap, ew);
      else n_pass++;
    end
  endtask

  task automatic test_freeze();
    step();  // second cycle of the dwell on channel 0
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++; if (F !== 4'd1) $display("FAIL frz_F[%0d]: got %0d exp 1", i, F); else n_pass++;
      n_total++; if (ch !== 2'd0) $display("FAIL frz_ch[%0d]: got %0d exp 0", i, ch); else n_pass++;
      n_total++; if (ch_stb !== 1'b0) $display("FAIL frz_stb[%0d]: got %b exp 0", i, ch_stb);
      else n_pass++;
    end
    en = 1'b1;
    step();
    n_total++; if (F !== 4'd1) $display("FAIL frz_resume1: got %0d exp 1", F); else n_pass++;
    step();
    n_total++; if (F !== 4'd2) $display("FAIL frz_resume2_F: got %0d exp 2", F); else n_pass++;
    n_total++; if (ch_stb !== 1'b1) $display("FAIL frz_resume2_stb: got %b exp 1", ch_stb);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step();
    step();
    step();
    n_total++; if (ch !== 2'd2) $display("FAIL ar_pre_ch: got %0d exp 2", ch); else n_pass++;
    n_total++; if (F !== 4'd3) $display("FAIL ar_pre_F: got %0d exp 3", F); else n_pass++;
    step();
    #3;
    rst = 1'b1;
    #1;
    n_total++; if (F !== 4'd0) $display("FAIL ar_F: got %0d exp 0", F); else n_pass++;
    n_total++; if (ch !== 2'd0) $display("FAIL ar_ch: got %0d exp 0", ch); else n_pass++;
    #1;
    rst = 1'b0;
    step();
    n_total++; if (F !== 4'd1) $display("FAIL ar_post1_F: got %0d exp 1", F); else n_pass++;
    n_total++; if (ch !== 2'd0) $display("FAIL ar_post1_ch: got %0d exp 0", ch); else n_pass++;
    step();
    step();
    n_total++; if (ch !== 2'd1) $display("FAIL ar_post3_ch: got %0d exp 1", ch); else n_pass++;
    n_total++; if (F !== 4'd2) $display("FAIL ar_post3_F: got %0d exp 2", F); else n_pass++;
  endtask

  task automatic test_out_of_range();
    mode = 1'b0; sel = 2'd0; sel3 = 2'd2;
    step();
    n_total++; if (F3 !== 4'd7) $display("FAIL oor_F3_sel2: got %0d exp 7", F3); else n_pass++;
    n_total++; if (ch3 !== 2'd2) $display("FAIL oor_ch3_sel2: got %0d exp 2", ch3); else n_pass++;
    sel3 = 2'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (F3 !== 4'd7) $display("FAIL oor_F3[%0d]: got %0d exp 7", i, F3); else n_pass++;
      n_total++; if (ch3 !== 2'd2) $display("FAIL oor_ch3[%0d]: got %0d exp 2", i, ch3);
      else n_pass++;
      n_total++; if (ch_stb3 !== 1'b0) $display("FAIL oor_stb3[%0d]: got %b exp 0", i, ch_stb3);
      else n_pass++;
    end
    sel3 = 2'd0;
    step();
    n_total++; if (F3 !== 4'd5) $display("FAIL oor_F3_sel0: got %0d exp 5", F3); else n_pass++;
    n_total++; if (ch_stb3 !== 1'b1) $display("FAIL oor_stb3_sel0: got %b exp 1", ch_stb3);
    else n_pass++;
  endtask

  // Leaving scan on the terminal-count edge must not advance the channel.
  task automatic test_mode_change();
    mode = 1'b1;
    step();
    step();
    step();
    mode = 1'b0;
    step();
    n_total++; if (ch !== 2'd0) $display("FAIL mc_term_ch: got %0d exp 0", ch); else n_pass++;
    n_total++; if (ch_stb !== 1'b0) $display("FAIL mc_term_stb: got %b exp 0", ch_stb);
    else n_pass++;
    mode = 1'b1;
    step();
    step();
    step();
    n_total++; if (F !== 4'd1) $display("FAIL mc_dwell_F: got %0d exp 1", F); else n_pass++;
    step();
    n_total++; if (F !== 4'd2) $display("FAIL mc_adv_F: got %0d exp 2", F); else n_pass++;
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask();
    ch_mask = 4'b1010;
    en = 1'b1; mode = 1'b1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    n_total++; if (F !== 4'd1) $display("FAIL msk_r1_F: got %0d exp 1", F); else n_pass++;
    step(); step();
    n_total++; if (ch !== 2'd1) $display("FAIL msk_r3_ch: got %0d exp 1", ch); else n_pass++;
    n_total++; if (F !== 4'd2) $display("FAIL msk_r3_F: got %0d exp 2", F); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL msk_r3_wrap: got %b exp 0", wrap); else n_pass++;
    step(); step(); step();
    n_total++; if (ch !== 2'd3) $display("FAIL msk_r6_ch: got %0d exp 3", ch); else n_pass++;
    n_total++; if (F !== 4'd4) $display("FAIL msk_r6_F: got %0d exp 4", F); else n_pass++;
    step(); step(); step();
    n_total++; if (ch !== 2'd1) $display("FAIL msk_r9_ch: got %0d exp 1", ch); else n_pass++;
    n_total++; if (wrap !== 1'b1) $display("FAIL msk_r9_wrap: got %b exp 1", wrap); else n_pass++;
    step(); step(); step();
    n_total++; if (ch !== 2'd3) $display("FAIL msk_r12_ch: got %0d exp 3", ch); else n_pass++;
    ch_mask = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step();
      n_total++; if (ch !== 2'd3) $display("FAIL msk0_ch[%0d]: got %0d exp 3", i, ch); else n_pass++;
      n_total++; if (F !== 4'd4) $display("FAIL msk0_F[%0d]: got %0d exp 4", i, F); else n_pass++;
      n_total++; if ((ch_stb | wrap) !== 1'b0)
        $display("FAIL msk0_strobes[%0d]: got %b%b exp 00", i, ch_stb, wrap);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; sel3 = 2'd0;
    din = 16'h4321; din3 = 12'h765;
`ifdef MUX_SCAN_MASK_EN
    ch_mask = 4'b1111; ch_mask3 = 3'b111;
`endif
    test_reset();
    test_manual();
    test_scan();
    test_freeze();
    test_async_reset();
    test_out_of_range();
    test_mode_change();
`ifdef MUX_SCAN_MASK_EN
    test_mask();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
